// File: rtl/uart_rx_port_pkg.sv
// Shared definitions for the uart_rx_port receiver: FSM state encodings and framing constants.
package uart_rx_port_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
    StStop  = 3'd3,
    StBrk   = 3'd4
  } rx_state_e;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_SAMPLE = 8;
  localparam int unsigned DATA_BITS  = 8;

endpackage

// File: rtl/uart_rx_port_sync_fifo.sv
// Show-ahead synchronous FIFO with registered occupancy count; power-of-two DEPTH.
module uart_rx_port_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_core,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_core) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_core) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_rx_port.sv
// 8N1 UART receiver with 16x oversampling, RX FIFO and sticky error flags.
// Define UART_RX_CTS_EN to build the registered cts_n threshold; otherwise cts_n is tied low.
module uart_rx_port
  import uart_rx_port_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = 22,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CTS_MARGIN = 4
) (
  input  logic       clk_core,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd,
  input  logic       clr_err,
  output logic [7:0] rd_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       cts_n
);

  localparam int unsigned PW = $clog2(BAUD_DIV);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic            rx_meta_q, rxs_q;
  rx_state_e       state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [3:0]      tick_cnt_q, tick_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            tick, push, frame_set, overrun_set;
  logic            frame_err_q, overrun_q;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;

  always_ff @(posedge clk_core) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  assign tick = (state_q != StIdle) && (presc_q == PW'(BAUD_DIV - 1));

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    push       = 1'b0;
    frame_set  = 1'b0;

    // Prescaler idles at zero so the first tick lands BAUD_DIV cycles after the start edge.
    if (state_q == StIdle || tick) presc_d = '0;
    else                           presc_d = presc_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        if (!rxs_q) begin
          state_d    = StStart;
          tick_cnt_d = '0;
        end
      end
      StStart: begin
        if (tick) begin
          if (tick_cnt_q == 4'(MID_SAMPLE - 1)) begin
            tick_cnt_d = '0;
            bit_idx_d  = '0;
            state_d    = rxs_q ? StIdle : StData;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      StData: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
          if (tick_cnt_q == 4'(OVERSAMPLE - 1)) begin
            shreg_d = {rxs_q, shreg_q[7:1]};
            if (bit_idx_q == 3'(DATA_BITS - 1)) state_d = StStop;
            else                                bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
          if (tick_cnt_q == 4'(OVERSAMPLE - 1)) begin
            if (rxs_q) begin
              push    = 1'b1;
              state_d = StIdle;
            end else begin
              frame_set = 1'b1;
              state_d   = StBrk;
            end
          end
        end
      end
      StBrk: begin
        if (rxs_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_core) begin
    if (reset) begin
      state_q    <= StIdle;
      presc_q    <= '0;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
    end
  end

  uart_rx_port_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_core  (clk_core),
    .reset     (reset),
    .push      (push),
    .push_data (shreg_q),
    .pop       (rd),
    .pop_data  (rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rx_valid    = !fifo_empty;
  assign overrun_set = push && fifo_full && !rd;

  // Set events take priority over a same-cycle clear.
  always_ff @(posedge clk_core) begin
    if (reset) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_set   | (frame_err_q & ~clr_err);
      overrun_q   <= overrun_set | (overrun_q   & ~clr_err);
    end
  end

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

`ifdef UART_RX_CTS_EN
  logic cts_n_q;

  always_ff @(posedge clk_core) begin
    if (reset) cts_n_q <= 1'b1;
    else       cts_n_q <= (fifo_count >= CW'(FIFO_DEPTH - CTS_MARGIN));
  end

  assign cts_n = cts_n_q;
`else
  logic unused_fifo_count;
  assign unused_fifo_count = ^fifo_count;
  assign cts_n = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_port.sv
// Self-checking bench for uart_rx_port: 8N1 frames driven on rx, popped bytes checked
// against a scoreboard queue filled as frames are sent.
module tb_uart_rx_port;

  localparam int unsigned BIT_CYC = 64;
  localparam int unsigned DEPTH   = 16;

`ifdef UART_RX_CTS_EN
  localparam logic CTS_RST  = 1'b1;
  localparam logic CTS_HIGH = 1'b1;
`else
  localparam logic CTS_RST  = 1'b0;
  localparam logic CTS_HIGH = 1'b0;
`endif

  logic       clk_core;
  logic       reset;
  logic       rx;
  logic       rd;
  logic       clr_err;
  logic [7:0] rd_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       cts_n;

  int total;
  int bad;

  logic [7:0] exp_q[$];
  int         model_cnt;
  logic       exp_overrun;
  logic [7:0] exp_b;

  uart_rx_port #(
    .BAUD_DIV   (4),
    .FIFO_DEPTH (16),
    .CTS_MARGIN (4)
  ) dut (
    .clk_core  (clk_core),
    .reset     (reset),
    .rx        (rx),
    .rd        (rd),
    .clr_err   (clr_err),
    .rd_data   (rd_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .cts_n     (cts_n)
  );

  initial clk_core = 1'b0;
  always #5 clk_core = ~clk_core;

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_core);
    #1;
  endtask

  // Drives one frame; rx is left at the stop-bit level afterwards.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    if (stop) begin
      if (model_cnt < DEPTH) begin
        exp_q.push_back(b);
        model_cnt++;
      end else begin
        exp_overrun = 1'b1;
      end
    end
    @(posedge clk_core);
    #1 rx = f[0];
    for (int c = 1; c <= 10 * BIT_CYC; c++) begin
      @(posedge clk_core);
      #1;
      if ((c % BIT_CYC) == 0 && c < 10 * BIT_CYC) rx = f[c / BIT_CYC];
    end
  endtask

  task automatic pop_one();
    rd = 1'b1;
    @(posedge clk_core);
    #1 rd = 1'b0;
    if (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      model_cnt--;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycles(3);
    total++;
    if (rx_valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0 || rd_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs: valid=%b ferr=%b ovr=%b data=%h, required 0 0 0 00",
               rx_valid, frame_err, overrun, rd_data);
    end
    total++;
    if (cts_n !== CTS_RST) begin
      bad++;
      $display("FAIL reset_cts: cts_n=%b required %b", cts_n, CTS_RST);
    end
    reset = 1'b0;
    cycles(1);
    total++;
    if (cts_n !== 1'b0) begin
      bad++;
      $display("FAIL cts_after_reset: cts_n=%b required 0", cts_n);
    end
    cycles(20);
  endtask

  task automatic test_single_byte();
    // Stop sample falls on the 611th edge after rx first goes low (2 sync + 152 ticks of 4).
    fork
      send_frame(8'hA5, 1'b1);
      begin
        @(posedge clk_core);
        repeat (610) @(posedge clk_core);
        #1;
        total++;
        if (rx_valid !== 1'b0) begin
          bad++;
          $display("FAIL latency_early: rx_valid=%b required 0", rx_valid);
        end
        @(posedge clk_core);
        #1;
        total++;
        if (rx_valid !== 1'b1 || rd_data !== exp_q[0]) begin
          bad++;
          $display("FAIL latency_byte: valid=%b data=%h, required 1 %h", rx_valid, rd_data,
                   exp_q[0]);
        end
      end
    join
    pop_one();
    total++;
    if (rx_valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL single_after_pop: valid=%b ferr=%b ovr=%b, required 0 0 0",
               rx_valid, frame_err, overrun);
    end
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    cycles(20);
    rx = 1'b1;
    cycles(12 * BIT_CYC);
    total++;
    if (rx_valid !== 1'b0 || frame_err !== 1'b0) begin
      bad++;
      $display("FAIL glitch: valid=%b ferr=%b, required 0 0", rx_valid, frame_err);
    end
  endtask

  task automatic test_frame_error();
    send_frame(8'h3C, 1'b0);
    cycles(200);
    total++;
    if (frame_err !== 1'b1 || rx_valid !== 1'b0) begin
      bad++;
      $display("FAIL frame_err_set: ferr=%b valid=%b, required 1 0", frame_err, rx_valid);
    end
    clr_err = 1'b1;
    cycles(1);
    clr_err = 1'b0;
    total++;
    if (frame_err !== 1'b0) begin
      bad++;
      $display("FAIL frame_err_clear: ferr=%b required 0", frame_err);
    end
    // Line still in break: no further error may appear.
    cycles(300);
    rx = 1'b1;
    cycles(100);
    total++;
    if (frame_err !== 1'b0 || rx_valid !== 1'b0) begin
      bad++;
      $display("FAIL break_single_error: ferr=%b valid=%b, required 0 0", frame_err, rx_valid);
    end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 1'b1);
      if (i == 15) begin
        total++;
        if (overrun !== 1'b0) begin
          bad++;
          $display("FAIL overrun_at_full: overrun=%b required 0", overrun);
        end
      end
    end
    total++;
    if (overrun !== exp_overrun) begin
      bad++;
      $display("FAIL overrun_set: overrun=%b required %b", overrun, exp_overrun);
    end
    for (int i = 0; i < 16; i++) begin
      exp_b = exp_q[0];
      total++;
      if (rx_valid !== 1'b1 || rd_data !== exp_b) begin
        bad++;
        $display("FAIL overrun_drain[%0d]: valid=%b data=%h, required 1 %h", i, rx_valid,
                 rd_data, exp_b);
      end
      pop_one();
    end
    total++;
    if (rx_valid !== 1'b0) begin
      bad++;
      $display("FAIL overrun_empty: rx_valid=%b required 0", rx_valid);
    end
    clr_err = 1'b1;
    cycles(1);
    clr_err = 1'b0;
    exp_overrun = 1'b0;
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL overrun_clear: overrun=%b required 0", overrun);
    end
  endtask

  task automatic test_cts();
    for (int i = 0; i < 12; i++) begin
      send_frame(8'hC0 + 8'(i), 1'b1);
      if (i == 10) begin
        total++;
        if (cts_n !== 1'b0) begin
          bad++;
          $display("FAIL cts_11: cts_n=%b required 0", cts_n);
        end
      end
    end
    total++;
    if (cts_n !== CTS_HIGH) begin
      bad++;
      $display("FAIL cts_12: cts_n=%b required %b", cts_n, CTS_HIGH);
    end
    exp_b = exp_q[0];
    total++;
    if (rd_data !== exp_b) begin
      bad++;
      $display("FAIL cts_head: data=%h required %h", rd_data, exp_b);
    end
    pop_one();
    total++;
    if (cts_n !== CTS_HIGH) begin
      bad++;
      $display("FAIL cts_lag: cts_n=%b required %b", cts_n, CTS_HIGH);
    end
    cycles(1);
    total++;
    if (cts_n !== 1'b0) begin
      bad++;
      $display("FAIL cts_release: cts_n=%b required 0", cts_n);
    end
    for (int i = 0; i < 11; i++) begin
      exp_b = exp_q[0];
      total++;
      if (rx_valid !== 1'b1 || rd_data !== exp_b) begin
        bad++;
        $display("FAIL cts_drain[%0d]: valid=%b data=%h, required 1 %h", i, rx_valid,
                 rd_data, exp_b);
      end
      pop_one();
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    b = 8'h55;
    rx = 1'b0;
    cycles(BIT_CYC);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      cycles(BIT_CYC);
    end
    rx = b[3];
    cycles(BIT_CYC / 2);
    reset = 1'b1;
    rx = 1'b1;
    cycles(3);
    reset = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    cycles(50);
    total++;
    if (rx_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_discard: rx_valid=%b required 0", rx_valid);
    end
    send_frame(8'h81, 1'b1);
    cycles(10);
    exp_b = exp_q[0];
    total++;
    if (rx_valid !== 1'b1 || rd_data !== exp_b) begin
      bad++;
      $display("FAIL post_reset_byte: valid=%b data=%h, required 1 %h", rx_valid, rd_data,
               exp_b);
    end
    pop_one();
    total++;
    if (rx_valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_flags: valid=%b ferr=%b ovr=%b, required 0 0 0",
               rx_valid, frame_err, overrun);
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    model_cnt   = 0;
    exp_overrun = 1'b0;
    reset       = 1'b1;
    rx          = 1'b1;
    rd          = 1'b0;
    clr_err     = 1'b0;
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_cts();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
